// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bus shared between the requesters and the arbiter.
interface rf_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               busy;

  // Requester side: drives requests, observes grants and the rf write port.
  modport master (
    output req, req_addr, req_data,
    input  gnt, rf_we, rf_waddr, rf_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_data,
    output gnt, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Grant, address, data and write enable are registered; busy is combinational.
module rf_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 4
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            hold,
  rf_wr_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Find the first eligible requester scanning upward from ptr with wrap.
  always_comb begin
    int unsigned idx;
    elig  = bus.req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && elig[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Route the winner's address/data slice.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_addr = bus.req_addr[i*AW +: AW];
        win_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Next grant state; address/data and ptr hold when nothing is granted.
  always_comb begin
    gnt_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    if (!hold && found) begin
      gnt_d[win] = 1'b1;
      waddr_d    = win_addr;
      wdata_d    = win_data;
      we_d       = |win_addr;
      ptr_d      = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
    end
  end

  // Grant and write-port registers; reset kills any in-flight write.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy     = |(bus.req & ~gnt_q);

endmodule
